// File: rtl/cmd_strobe_gen.sv
// cmd_strobe_gen
// Conditions six raw push-buttons and turns each clean press into a single
// one-hot command for the main control block. The command is presented for
// one set-up cycle, strobed with MEn_o for EN_WIDTH cycles, held for one more
// cycle, and then the block waits for every button to be released before it
// accepts another press.
//
// Button / command bit order used throughout:
//   [0] aumf  [1] bajaf  [2] aumC  [3] bajaC  [4] MODO  [5] MRst
module cmd_strobe_gen #(
  parameter logic [15:0] DEB_CYCLES = 16'd50000,
  parameter logic [3:0]  EN_WIDTH   = 4'd1,
  parameter int          CNT_W      = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_aumf,
  input  logic btn_bajaf,
  input  logic btn_aumC,
  input  logic btn_bajaC,
  input  logic btn_modo,
  input  logic btn_rst,
  output logic aumf_o,
  output logic bajaf_o,
  output logic aumC_o,
  output logic bajaC_o,
  output logic MODO_o,
  output logic MRst_o,
  output logic MEn_o,
  output logic busy_o
);

  localparam int NBTN = 6;

  // The level flips on the edge where the counter would reach DEB_CYCLES,
  // so the terminal value held in the counter is DEB_CYCLES-1.
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 16'd1);

  // FSM encoding
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SETUP    = 3'd1;
  localparam logic [2:0] ST_STROBE   = 3'd2;
  localparam logic [2:0] ST_HOLD     = 3'd3;
  localparam logic [2:0] ST_WAIT_REL = 3'd4;

  // Raw buttons gathered into one vector in command bit order
  logic [NBTN-1:0] w_btn_raw;
  assign w_btn_raw = {btn_rst, btn_modo, btn_bajaC, btn_aumC, btn_bajaf, btn_aumf};

  // Synchroniser stages
  logic [NBTN-1:0] r_sync1;
  logic [NBTN-1:0] r_sync2;

  // Debounce state
  logic [NBTN-1:0] r_deb;
  logic [NBTN-1:0] r_deb_prev;
  logic [CNT_W-1:0] r_cnt [NBTN];

  // Press events and the priority winner
  logic [NBTN-1:0] w_press;
  logic [NBTN-1:0] w_win;

  // Sequencer
  logic [2:0]      r_state;
  logic [2:0]      w_state_nxt;
  logic [3:0]      r_en_cnt;
  logic [NBTN-1:0] r_cmd;
  logic            r_men;
  logic            r_busy;

  // Two-flop synchroniser: only r_sync2 feeds the rest of the design
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours, exactly like the hardware does.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Per-button debounce: count consecutive cycles that disagree with the
  // debounced level, flip the level after DEB_CYCLES of them
  // NOTE: the counter array is reset explicitly because the debounce
  // behaviour after reset depends on every counter starting from zero; it is
  // a small bank of flops, not a RAM, so the reset costs nothing structural.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_deb <= '0;
      for (int i = 0; i < NBTN; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NBTN; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] >= DEB_LAST) begin
          // Disagreement has lasted DEB_CYCLES cycles: accept the new level.
          r_cnt[i] <= '0;
          r_deb[i] <= ~r_deb[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Previous-cycle copy of the debounced levels for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_deb_prev <= '0;
    end else begin
      r_deb_prev <= r_deb;
    end
  end

  assign w_press = r_deb & ~r_deb_prev;

  // Fixed priority: MRst > MODO > aumf > bajaf > aumC > bajaC
  // NOTE: combinational blocks use blocking (=) and give every output a
  // default first, so no path leaves a signal unassigned and no latch appears.
  always_comb begin
    w_win = '0;
    if (w_press[5]) begin
      w_win = 6'b10_0000;
    end else if (w_press[4]) begin
      w_win = 6'b01_0000;
    end else if (w_press[0]) begin
      w_win = 6'b00_0001;
    end else if (w_press[1]) begin
      w_win = 6'b00_0010;
    end else if (w_press[2]) begin
      w_win = 6'b00_0100;
    end else if (w_press[3]) begin
      w_win = 6'b00_1000;
    end
  end

  // Next-state selection for the set-up / strobe / hold / wait-release cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (|w_press) begin
          w_state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        w_state_nxt = ST_STROBE;
      end
      ST_STROBE: begin
        if (r_en_cnt >= EN_WIDTH) begin
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        w_state_nxt = ST_WAIT_REL;
      end
      ST_WAIT_REL: begin
        // Presses that arrived while busy are dropped; waiting for a full
        // release guarantees a held loser can only fire via a fresh edge.
        if (r_deb == '0) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register with busy flag registered alongside it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  // Strobe length counter: 1 on entry to STROBE, counts up while in STROBE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en_cnt <= '0;
    end else if (r_state == ST_SETUP) begin
      r_en_cnt <= 4'd1;
    end else if ((r_state == ST_STROBE) && (w_state_nxt == ST_STROBE)) begin
      r_en_cnt <= r_en_cnt + 4'd1;
    end
  end

  // Registered command lines: latch the winner on leaving IDLE, clear on
  // entering WAIT_REL (or on any unexpected return to IDLE)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd <= '0;
    end else if ((r_state == ST_IDLE) && (|w_press)) begin
      r_cmd <= w_win;
    end else if ((w_state_nxt == ST_WAIT_REL) || (w_state_nxt == ST_IDLE)) begin
      r_cmd <= '0;
    end
  end

  // Registered load-enable: high for exactly the cycles spent in STROBE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_men <= 1'b0;
    end else begin
      r_men <= (w_state_nxt == ST_STROBE);
    end
  end

  assign aumf_o  = r_cmd[0];
  assign bajaf_o = r_cmd[1];
  assign aumC_o  = r_cmd[2];
  assign bajaC_o = r_cmd[3];
  assign MODO_o  = r_cmd[4];
  assign MRst_o  = r_cmd[5];
  assign MEn_o   = r_men;
  assign busy_o  = r_busy;

endmodule

// File: doc/cmd_strobe_gen.md
Name: cmd_strobe_gen

Overview:
- Front end that drives the command inputs of the main control block (aumf, bajaf, aumC, bajaC, MODO, MRst) and its load-enable MEn.
- Conditions six raw push-buttons:
  - two-flop synchroniser per button;
  - per-button debounce;
  - rising-edge detection;
  - fixed priority selection.
- Issues one command per press as a set-up / strobe / hold sequence, so the consumer latches clean, stable one-hot commands on MEn.

Parameters:
- DEB_CYCLES, 16'd50000, consecutive stable cycles required before a debounced level changes (minimum 2).
- EN_WIDTH, 4'd1, number of cycles MEn stays high per command (minimum 1).
- CNT_W, 16, width of the debounce counters (must hold DEB_CYCLES).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous active-high reset
- btn_aumf  in  1  raw button, raise f
- btn_bajaf  in  1  raw button, lower f
- btn_aumC  in  1  raw button, raise C
- btn_bajaC  in  1  raw button, lower C
- btn_modo  in  1  raw button, mode
- btn_rst  in  1  raw button, master reset command
- aumf_o  out  1  command line to the control block
- bajaf_o  out  1  command line to the control block
- aumC_o  out  1  command line to the control block
- bajaC_o  out  1  command line to the control block
- MODO_o  out  1  command line to the control block
- MRst_o  out  1  command line to the control block
- MEn_o  out  1  load-enable strobe for the control block
- busy_o  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (async assert, sync release):
  - all outputs 0;
  - synchronisers, debounced levels, edge registers and counters 0;
  - FSM goes to IDLE.
- Synchroniser: two flops per button; only the second-stage output is used.
- Debounce, per button:
  - counter clears whenever the synchronised value equals the debounced level;
  - counter increments otherwise;
  - when the counter reaches DEB_CYCLES, the debounced level flips and the counter clears;
  - release is debounced identically;
  - counter never wraps.
- Edge detect: press event = debounced level 1 and its previous-cycle copy 0.
- Priority when several press events occur in the same cycle: MRst > MODO > aumf > bajaf > aumC > bajaC. Only the winner is issued; losers are dropped, not queued.
- Registered outputs; exactly zero or one command line is high at any time.
- FSM:
  - IDLE: outputs 0. On any press event, register the winner one-hot on the command lines and go to SETUP.
  - SETUP (1 cycle): command held, MEn_o=0. Go to STROBE.
  - STROBE (EN_WIDTH cycles): command held, MEn_o=1. Go to HOLD.
  - HOLD (1 cycle): command held, MEn_o=0. Go to WAIT_REL.
  - WAIT_REL: command lines and MEn_o 0. Stay until all six debounced levels are 0, then go to IDLE.
- Press events arising outside IDLE are ignored. A second button pressed while the first is held never fires; it fires only if it is still pressed (re-debounced rising edge) after a full release.
- Latency: with raw high first sampled at edge N and stable, the command line is high after edge N+DEB_CYCLES+2 and MEn_o rises one cycle later.
- Per press, command lines are high for exactly EN_WIDTH+2 cycles and MEn_o for EN_WIDTH cycles, nested strictly inside.
- Bounce shorter than DEB_CYCLES produces no event. A held button produces exactly one command (no auto-repeat).
- Reset mid-sequence:
  - outputs drop to 0 immediately, asynchronously;
  - a button still held across reset release re-debounces from level 0 and issues one new command.
- busy_o = (state != IDLE), registered with the state.

Test Plan (DEB_CYCLES=4, EN_WIDTH=2):
- Reset: hold rst high mid-STROBE with btn_aumf pressed -> all outputs 0 within the reset cycle. After release with btn_aumf still high -> exactly one aumf_o sequence, starting 6 cycles after the first sampling edge.
- Single press: btn_aumC high 20 cycles -> aumC_o high 4 cycles, MEn_o high cycles 2-3 of those, busy_o high until release is debounced, no second command.
- Bounce: btn_bajaf toggled high 3 cycles / low 1 cycle, repeated 5 times, then low -> no output activity, busy_o stays 0.
- Priority: btn_modo and btn_aumf raised on the same edge, held 15 cycles -> only MODO_o pulses; after release and idle, no aumf_o pulse.
- Press during busy: btn_bajaC held, then btn_rst raised during STROBE and released before btn_bajaC -> only bajaC_o issued. Then btn_rst pressed alone after full release -> MRst_o issued.
- Consecutive presses: three separated btn_aumf presses (10 high / 10 low cycles) -> three identical aumf_o/MEn_o sequences; a scoreboard checks at most one command line is high in every cycle.
